// File: rtl/scrambler_pkg.sv
// Shared scrambler word/key types, used by the arbiter and the scrambler bench.
package scrambler_pkg;
  localparam int DATA_W = 32;
  localparam int KEY_W  = 16;

  typedef logic [DATA_W-1:0] scr_word_t;
  typedef logic [KEY_W-1:0]  scr_key_t;
endpackage

// File: rtl/scr_rsp_fifo.sv
// Result FIFO of {id, word} entries; pointers wrap at FIFO_DEPTH (not
// necessarily a power of two). The head reads as zero while the FIFO is empty.
module scr_rsp_fifo #(
  parameter  int WIDTH      = 34,
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_s, full_s;

  assign pop_s   = pop_i && (count_q != '0);
  assign full_s  = (count_q == CNT_W'(FIFO_DEPTH));
  assign count_o = count_q;
  assign rdata_o = (count_q == '0) ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_i) begin
      wr_d = (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end else begin
      rd_d = rd_q;
    end
    case ({push_i, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  scr_rsp_fifo_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_i),
    .pop_i  (pop_s),
    .full_i (full_s)
  );
endmodule

// File: rtl/scr_rsp_fifo_chk.sv
// Simulation-only checker for the response FIFO: a push into a full FIFO
// means the credit accounting upstream is broken.
module scr_rsp_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push_i,
  input logic pop_i,
  input logic full_i
);
  no_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push_i && full_i && !pop_i));
endmodule

// File: rtl/scrambler_arb.sv
// Round-robin arbiter sharing one external scrambler among NREQ requesters,
// with credit-based flow control into a tagged result FIFO.
module scrambler_arb
  import scrambler_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = $clog2(NREQ),
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int SUM_W      = CNT_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ*KEY_W-1:0]  req_key,
  output logic                   scr_enable,
  output scr_word_t              scr_data,
  output scr_key_t               scr_pad_key,
  input  scr_word_t              scr_dout,
  input  logic                   scr_pushout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output scr_word_t              rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   err
);
  logic [ID_W-1:0]        last_grant_q, last_grant_d;
  logic [ID_W-1:0]        pend_id_q, pend_id_d;
  logic                   inflight_q, inflight_d;
  logic                   err_q, err_d;
  logic [ID_W-1:0]        grant_id_s;
  logic                   found_s, credit_ok_s, issue_s, push_s, pop_s;
  logic [CNT_W-1:0]       fifo_count_s;
  logic [SUM_W-1:0]       occ_s;
  logic [ID_W+DATA_W-1:0] fifo_rdata_s;

  // A word popped this cycle is still counted, so credit frees one cycle late.
  assign occ_s       = SUM_W'(fifo_count_s) + SUM_W'(inflight_q);
  assign credit_ok_s = (occ_s < SUM_W'(FIFO_DEPTH));
  assign issue_s     = found_s && credit_ok_s && !rst;

  always_comb begin
    found_s    = 1'b0;
    grant_id_s = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found_s && req_valid[ID_W'((int'(last_grant_q) + i) % NREQ)]) begin
        found_s    = 1'b1;
        grant_id_s = ID_W'((int'(last_grant_q) + i) % NREQ);
      end else begin
        found_s    = found_s;
      end
    end
  end

  always_comb begin
    req_ready   = '0;
    scr_enable  = 1'b0;
    scr_data    = '0;
    scr_pad_key = '0;
    if (issue_s) begin
      req_ready[grant_id_s] = 1'b1;
      scr_enable            = 1'b1;
      scr_data              = req_data[int'(grant_id_s)*DATA_W +: DATA_W];
      scr_pad_key           = req_key[int'(grant_id_s)*KEY_W +: KEY_W];
    end else begin
      scr_enable            = 1'b0;
    end
  end

  always_comb begin
    last_grant_d = issue_s ? grant_id_s : last_grant_q;
    pend_id_d    = issue_s ? grant_id_s : pend_id_q;
    inflight_d   = issue_s;
    push_s       = scr_pushout && inflight_q;
    err_d        = err_q || (scr_pushout && !inflight_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= ID_W'(NREQ - 1);
      pend_id_q    <= '0;
      inflight_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      pend_id_q    <= pend_id_d;
      inflight_q   <= inflight_d;
      err_q        <= err_d;
    end
  end

  scr_rsp_fifo #(
    .WIDTH      (ID_W + DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .wdata_i ({pend_id_q, scr_dout}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_count_s)
  );

  assign rsp_valid = (fifo_count_s != '0);
  assign pop_s     = rsp_valid && rsp_ready;
  assign rsp_data  = fifo_rdata_s[DATA_W-1:0];
  assign rsp_id    = fifo_rdata_s[ID_W+DATA_W-1 -: ID_W];
  assign err       = err_q;
endmodule

// File: tb/tb_scrambler_arb.sv
// Directed bench for scrambler_arb with a one-cycle behavioural scrambler
// (dout = data ^ {key, ~key}) standing in for the real block.
module tb_scrambler_arb;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ*16-1:0] req_key;
  logic              scr_enable;
  logic [31:0]       scr_data;
  logic [15:0]       scr_pad_key;
  logic [31:0]       scr_dout;
  logic              scr_pushout;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_id;
  logic              err;
  logic              force_push = 1'b0;

  logic [31:0] data_tab [0:NREQ-1];
  logic [15:0] key_tab  [0:NREQ-1];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    req_key  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*32 +: 32] = data_tab[i];
      req_key[i*16 +: 16]  = key_tab[i];
    end
  end

  function automatic logic [31:0] scr_model(input logic [31:0] d, input logic [15:0] k);
    return d ^ {k, ~k};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      scr_pushout <= 1'b0;
      scr_dout    <= '0;
    end else begin
      scr_pushout <= scr_enable | force_push;
      scr_dout    <= scr_model(scr_data, scr_pad_key);
    end
  end

  scrambler_arb #(.NREQ(NREQ), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key), .scr_enable(scr_enable),
    .scr_data(scr_data), .scr_pad_key(scr_pad_key), .scr_dout(scr_dout),
    .scr_pushout(scr_pushout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .err(err)
  );

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; force_push = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    data_tab = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    key_tab  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    total++; if (scr_enable !== 1'b0) begin bad++; $display("FAIL reset_scr_enable got=%b exp=0", scr_enable); end
    total++; if (scr_data !== 32'h0) begin bad++; $display("FAIL reset_scr_data got=%h exp=0", scr_data); end
    total++; if (scr_pad_key !== 16'h0) begin bad++; $display("FAIL reset_scr_pad_key got=%h exp=0", scr_pad_key); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    data_tab[0] = 32'h0000_0001; key_tab[0] = 16'h0000;
    rsp_ready = 1'b1; req_valid = 4'b0001;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    total++; if (scr_enable !== 1'b1) begin bad++; $display("FAIL single_enable got=%b exp=1", scr_enable); end
    total++; if (scr_data !== 32'h0000_0001) begin bad++; $display("FAIL single_scr_data got=%h exp=00000001", scr_data); end
    total++; if (scr_pad_key !== 16'h0000) begin bad++; $display("FAIL single_scr_key got=%h exp=0000", scr_pad_key); end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
    total++; if (rsp_data !== 32'h0000_FFFE) begin bad++; $display("FAIL single_data got=%h exp=0000fffe", rsp_data); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [1:0] eid;
    do_reset();
    data_tab = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    key_tab  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (c < 8) begin
        total++; if (req_ready !== (4'b0001 << (c % 4))) begin bad++; $display("FAIL rr_grant c=%0d got=%b", c, req_ready); end
      end
      if (c >= 2) begin
        eid = 2'((c - 2) % 4);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_valid c=%0d got=%b exp=1", c, rsp_valid); end
        total++; if (rsp_id !== eid) begin bad++; $display("FAIL rr_id c=%0d got=%0d exp=%0d", c, rsp_id, eid); end
        total++; if (rsp_data !== scr_model(data_tab[eid], key_tab[eid])) begin bad++; $display("FAIL rr_data c=%0d got=%h", c, rsp_data); end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rr_drained got=%b exp=0", rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [1:0] eid;
    do_reset();
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (req_ready !== ((c < 4) ? (4'b0001 << c) : 4'b0000)) begin bad++; $display("FAIL bp_hold_grant c=%0d got=%b", c, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      eid = 2'(k % 4);
      @(negedge clk);
      total++; if (req_ready !== ((k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4)))) begin bad++; $display("FAIL bp_release_grant k=%0d got=%b", k, req_ready); end
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid k=%0d got=%b exp=1", k, rsp_valid); end
      total++; if (rsp_id !== eid) begin bad++; $display("FAIL bp_id k=%0d got=%0d exp=%0d", k, rsp_id, eid); end
      total++; if (rsp_data !== scr_model(data_tab[eid], key_tab[eid])) begin bad++; $display("FAIL bp_data k=%0d got=%h", k, rsp_data); end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    logic [1:0] eid;
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 4'b1010 : 4'b0000;
      @(negedge clk);
      if (c < 4) begin
        total++; if (req_ready !== (((c % 2) == 0) ? 4'b0010 : 4'b1000)) begin bad++; $display("FAIL fair_grant c=%0d got=%b", c, req_ready); end
      end
      if (c >= 2) begin
        eid = ((c % 2) == 0) ? 2'd1 : 2'd3;
        total++; if (rsp_id !== eid || rsp_valid !== 1'b1) begin bad++; $display("FAIL fair_rsp c=%0d got=%0d/%b exp=%0d/1", c, rsp_id, rsp_valid, eid); end
        total++; if (rsp_data !== scr_model(data_tab[eid], key_tab[eid])) begin bad++; $display("FAIL fair_data c=%0d got=%h", c, rsp_data); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (req_ready !== (4'b0001 << c)) begin bad++; $display("FAIL mid_fill_grant c=%0d got=%b", c, req_ready); end
      @(posedge clk); #1;
    end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_queued got=%b exp=1", rsp_valid); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", rsp_valid); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_grant got=%b exp=0000", req_ready); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
    @(posedge clk); #1; req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_stale got=%b exp=0", rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin bad++; $display("FAIL mid_rsp got=%b/%0d exp=1/0", rsp_valid, rsp_id); end
    total++; if (rsp_data !== scr_model(data_tab[0], key_tab[0])) begin bad++; $display("FAIL mid_data got=%h", rsp_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_spurious();
    do_reset();
    rsp_ready = 1'b1; force_push = 1'b1;
    @(negedge clk);
    total++; if (scr_enable !== 1'b0) begin bad++; $display("FAIL spur_enable got=%b exp=0", scr_enable); end
    @(posedge clk); #1; force_push = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL spur_err_early got=%b exp=0", err); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_err got=%b exp=1", err); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL spur_no_entry got=%b exp=0", rsp_valid); end
    @(posedge clk); #1; req_valid = 4'b0100;
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL spur_grant got=%b exp=0100", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin bad++; $display("FAIL spur_rsp got=%b/%0d exp=1/2", rsp_valid, rsp_id); end
    total++; if (rsp_data !== scr_model(data_tab[2], key_tab[2])) begin bad++; $display("FAIL spur_data got=%h", rsp_data); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_err_sticky got=%b exp=1", err); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      data_tab[i] = '0;
      key_tab[i]  = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
